// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Shared types, default sample format and pointer helper for the
//            fifo_flex buffer and its storage array.
// Revision : 1.0  initial release
// ============================================================================
package fifo_pkg;

    // Default fixed-point sample format (IL.FL)
    localparam int DEFAULT_IL = 4;
    localparam int DEFAULT_FL = 16;

    // Read-side behaviour of the buffer
    typedef enum logic [0:0] {
        FIFO_STD  = 1'b0,   // registered data_out, one-cycle read latency
        FIFO_FWFT = 1'b1    // head word presented combinationally, rd_en pops
    } fifo_mode_e;

    // Advance a pointer by one, wrapping from depth-1 back to zero by explicit
    // compare so that any depth (not only powers of two) is supported.
    function automatic int unsigned ptr_inc_wrap(input int unsigned ptr,
                                                 input int unsigned depth);
        return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : fifo_mem
// Purpose  : DEPTH x WIDTH register array with one synchronous write port and
//            one asynchronous read port. Contents are deliberately not reset.
// Revision : 1.0  initial release
// ============================================================================
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH  = 20,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] word_q [DEPTH];
    logic [WIDTH-1:0] word_d [DEPTH];

    // Next contents: only the addressed word takes the write data
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            word_d[i] = word_q[i];
            if (wr_en && (wr_addr == ADDR_W'(i))) begin
                word_d[i] = wr_data;
            end
        end
    end

    // Storage update (no reset: contents are don't-care until written)
    always_ff @(posedge clk) begin
        word_q <= word_d;
    end

    // Asynchronous read mux; addresses beyond DEPTH-1 never occur but read 0
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_data = word_q[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_flex.sv
`default_nettype none
// ============================================================================
// Module   : fifo_flex
// Purpose  : Parametrised synchronous FIFO for IL.FL sample streams with
//            standard or first-word-fall-through read mode, arbitrary depth,
//            occupancy count, almost-full/almost-empty thresholds and sticky
//            overflow/underflow error flags.
// Revision : 1.0  initial release
// ============================================================================
module fifo_flex
    import fifo_pkg::*;
#(
    parameter int IL           = DEFAULT_IL,
    parameter int FL           = DEFAULT_FL,
    parameter int IN_BUS_WIDTH = IL + FL,
    parameter int FIFO_DEPTH   = 32,
    parameter int FWFT         = 0,
    parameter int AF_THRESH    = FIFO_DEPTH - 2,
    parameter int AE_THRESH    = 2,
    parameter int CNT_WIDTH    = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [IN_BUS_WIDTH-1:0] data_in,
    input  logic                    wr_en,
    input  logic                    rd_en,
    output logic [IN_BUS_WIDTH-1:0] data_out,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [CNT_WIDTH-1:0]    count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int                   PTR_W    = $clog2(FIFO_DEPTH);
    localparam fifo_mode_e           MODE     = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] AF_LVL   = CNT_WIDTH'(AF_THRESH);
    localparam logic [CNT_WIDTH-1:0] AE_LVL   = CNT_WIDTH'(AE_THRESH);

    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]    count_q, count_d;
    logic                    overflow_q, overflow_d;
    logic                    underflow_q, underflow_d;

    logic                    w_empty;
    logic                    w_full;
    logic                    w_rd_accept;
    logic                    w_wr_accept;
    logic [IN_BUS_WIDTH-1:0] w_mem_rd_data;

    // Status decoded purely from the registered count, so request inputs
    // never reach a flag combinationally.
    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == CNT_FULL);

    // A read needs data; a write needs room, or a simultaneous pop that
    // frees the slot in the same cycle.
    assign w_rd_accept = rd_en && !w_empty;
    assign w_wr_accept = wr_en && (!w_full || w_rd_accept);

    // Pointer, occupancy and sticky-error next state
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (w_wr_accept) begin
            wr_ptr_d = PTR_W'(ptr_inc_wrap(32'(wr_ptr_q), FIFO_DEPTH));
        end
        if (w_rd_accept) begin
            rd_ptr_d = PTR_W'(ptr_inc_wrap(32'(rd_ptr_q), FIFO_DEPTH));
        end

        case ({w_wr_accept, w_rd_accept})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Dropped write (full with no pop) and read of an empty buffer latch
        if (wr_en && !w_wr_accept) begin
            overflow_d = 1'b1;
        end
        if (rd_en && w_empty) begin
            underflow_d = 1'b1;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .WIDTH  (IN_BUS_WIDTH),
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (w_wr_accept),
        .wr_addr (wr_ptr_q),
        .wr_data (data_in),
        .rd_addr (rd_ptr_q),
        .rd_data (w_mem_rd_data)
    );

    generate
        if (MODE == FIFO_STD) begin : g_std_out
            logic [IN_BUS_WIDTH-1:0] dout_q, dout_d;

            // Capture the head word on an accepted read, hold otherwise
            always_comb begin
                dout_d = dout_q;
                if (w_rd_accept) begin
                    dout_d = w_mem_rd_data;
                end
            end

            // Registered read data
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    dout_q <= '0;
                end else begin
                    dout_q <= dout_d;
                end
            end

            assign data_out = dout_q;
        end else begin : g_fwft_out
            // Head word straight from storage; forced to zero while empty so
            // the reset value and the idle value are well defined.
            assign data_out = w_empty ? '0 : w_mem_rd_data;
        end
    endgenerate

    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_full  = (count_q >= AF_LVL);
    assign almost_empty = (count_q <= AE_LVL);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_flex.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_flex
// Purpose  : Self-checking bench for fifo_flex. A standard-mode and an FWFT
//            instance (depth 5) share one stimulus stream; a queue-based
//            model predicts occupancy, flags, sticky errors and read data.
// Revision : 1.0  initial release
// ============================================================================
module tb_fifo_flex;

    localparam int W     = 20;
    localparam int DEPTH = 5;
    localparam int CW    = 3;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic          rd_en;
    logic [W-1:0]  din;

    logic [W-1:0]  s_dout, f_dout;
    logic          s_empty, s_full, s_af, s_ae, s_ovf, s_unf;
    logic          f_empty, f_full, f_af, f_ae, f_ovf, f_unf;
    logic [CW-1:0] s_count, f_count;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [W-1:0]  mq [$];
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;
    logic [W-1:0]  m_dout = '0;

    fifo_flex #(.IL(4), .FL(16), .FIFO_DEPTH(DEPTH), .FWFT(0)) u_std (
        .clk(clk), .reset(rst_n), .data_in(din), .wr_en(wr_en), .rd_en(rd_en),
        .data_out(s_dout), .empty(s_empty), .full(s_full),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf)
    );

    fifo_flex #(.IL(4), .FL(16), .FIFO_DEPTH(DEPTH), .FWFT(1)) u_fwft (
        .clk(clk), .reset(rst_n), .data_in(din), .wr_en(wr_en), .rd_en(rd_en),
        .data_out(f_dout), .empty(f_empty), .full(f_full),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Behavioural model: a queue of stored words plus sticky error bits
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_dout = '0;
        end else begin
            bit ra, wa;
            ra = rd_en && (mq.size() != 0);
            wa = wr_en && ((mq.size() < DEPTH) || ra);
            if (rd_en && !ra) m_unf = 1'b1;
            if (wr_en && !wa) m_ovf = 1'b1;
            if (ra) m_dout = mq.pop_front();
            if (wa) mq.push_back(din);
        end
    end

    // Cycle-by-cycle comparison on the falling edge
    always @(negedge clk) begin
        int n;
        n = mq.size();
        chk("s_count", 32'(s_count), 32'(n));
        chk("f_count", 32'(f_count), 32'(n));
        chk("s_empty", 32'(s_empty), 32'(n == 0));
        chk("f_empty", 32'(f_empty), 32'(n == 0));
        chk("s_full",  32'(s_full),  32'(n == DEPTH));
        chk("f_full",  32'(f_full),  32'(n == DEPTH));
        chk("s_af",    32'(s_af),    32'(n >= AF));
        chk("f_af",    32'(f_af),    32'(n >= AF));
        chk("s_ae",    32'(s_ae),    32'(n <= AE));
        chk("f_ae",    32'(f_ae),    32'(n <= AE));
        chk("s_ovf",   32'(s_ovf),   32'(m_ovf));
        chk("f_ovf",   32'(f_ovf),   32'(m_ovf));
        chk("s_unf",   32'(s_unf),   32'(m_unf));
        chk("f_unf",   32'(f_unf),   32'(m_unf));
        chk("s_dout",  32'(s_dout),  32'(m_dout));
        if (n > 0) chk("f_dout", 32'(f_dout), 32'(mq[0]));
    end

    // One clock of stimulus; returns 1 time unit after the edge
    task automatic cyc(input bit w, input bit r, input logic [W-1:0] d);
        wr_en = w;
        rd_en = r;
        din   = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int wp, rp;
        rst_n = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset values
        chk("rst_count", 32'(s_count), 0);
        chk("rst_empty", 32'(s_empty), 1);
        chk("rst_ae",    32'(s_ae),    1);
        chk("rst_full",  32'(s_full),  0);
        chk("rst_dout",  32'(s_dout),  0);

        // Single word, standard read
        cyc(1, 0, 101);
        chk("w101_count", 32'(s_count), 1);
        chk("w101_empty", 32'(s_empty), 0);
        chk("w101_fwft",  32'(f_dout),  101);
        cyc(0, 1, 0);
        chk("r101_dout",  32'(s_dout),  101);
        chk("r101_empty", 32'(s_empty), 1);
        chk("r101_count", 32'(s_count), 0);

        // FWFT streaming
        cyc(1, 0, 102);
        chk("fwft_first", 32'(f_dout), 102);
        cyc(1, 0, 103);
        cyc(1, 0, 104);
        cyc(0, 1, 0);
        chk("fwft_pop1", 32'(f_dout), 103);
        cyc(0, 1, 0);
        chk("fwft_pop2", 32'(f_dout), 104);
        cyc(0, 1, 0);
        chk("fwft_empty", 32'(f_empty), 1);
        chk("std_last",   32'(s_dout),  104);

        // Fill across the pointer wrap, overflow, drain
        for (int i = 1; i <= DEPTH; i++) begin
            cyc(1, 0, W'(i));
            if (i == 2) chk("af_at2", 32'(s_af), 0);
            if (i == 3) begin
                chk("af_at3", 32'(s_af), 1);
                chk("ae_at3", 32'(s_ae), 0);
            end
        end
        chk("fill_full", 32'(s_full), 1);
        cyc(1, 0, 99);
        chk("ovf_set",   32'(s_ovf),   1);
        chk("ovf_count", 32'(s_count), 5);
        for (int i = 1; i <= DEPTH; i++) begin
            cyc(0, 1, 0);
            chk("drain_dout", 32'(s_dout), 32'(i));
        end

        // Full with simultaneous read and write
        reset_pulse();
        chk("ovf_cleared", 32'(s_ovf), 0);
        for (int i = 1; i <= DEPTH; i++) cyc(1, 0, W'(i));
        cyc(1, 1, 200);
        chk("both_count", 32'(s_count), 5);
        chk("both_full",  32'(s_full),  1);
        chk("both_ovf",   32'(s_ovf),   0);
        for (int i = 1; i <= DEPTH; i++) begin
            cyc(0, 1, 0);
            chk("both_dout", 32'(s_dout), (i < DEPTH) ? 32'(i + 1) : 32'd200);
        end

        // Underflow, then read+write on empty
        cyc(0, 1, 0);
        chk("unf_set",  32'(s_unf),  1);
        chk("unf_hold", 32'(s_dout), 200);
        cyc(1, 1, 7);
        chk("e_both_count", 32'(s_count), 1);
        chk("e_both_fwft",  32'(f_dout),  7);
        cyc(0, 1, 0);
        chk("e_both_read",  32'(s_dout),  7);

        // Asynchronous reset mid-stream
        cyc(1, 0, 11);
        cyc(1, 0, 12);
        cyc(1, 0, 13);
        chk("pre_rst_count", 32'(s_count), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(s_count), 0);
        chk("arst_empty", 32'(s_empty), 1);
        chk("arst_full",  32'(s_full),  0);
        chk("arst_af",    32'(s_af),    0);
        chk("arst_ae",    32'(s_ae),    1);
        chk("arst_ovf",   32'(s_ovf),   0);
        chk("arst_unf",   32'(s_unf),   0);
        chk("arst_dout",  32'(s_dout),  0);
        chk("arst_fcnt",  32'(f_count), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomized traffic with varying read/write pressure
        wp = 50;
        rp = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                wp = (($urandom_range(2) == 0) ? 15 : (($urandom_range(1) == 0) ? 50 : 90));
                rp = (($urandom_range(2) == 0) ? 15 : (($urandom_range(1) == 0) ? 50 : 90));
            end
            if ($urandom_range(499) == 0) begin
                reset_pulse();
            end
            cyc($urandom_range(99) < wp, $urandom_range(99) < rp, W'($urandom));
        end

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
